// File: rtl/pc_next_unit_if.sv
// Fetch-side bus between the datapath and the next-PC unit.
// The datapath (master) requests redirects; the unit (slave) returns the PC and trap info.
interface pc_next_unit_if #(
   parameter int XLEN = 32
);
   logic            Stall;
   logic [1:0]      PCSrc;
   logic [XLEN-1:0] PCTarget;
   logic [XLEN-1:0] JalrTarget;
   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] PCPlus4;
   logic            PCValid;
   logic            MisalignTrap;
   logic [XLEN-1:0] EPC;
   logic [XLEN-1:0] BadAddr;

   modport master (
      output Stall, PCSrc, PCTarget, JalrTarget,
      input  PC, PCPlus4, PCValid, MisalignTrap, EPC, BadAddr
   );

   modport slave (
      input  Stall, PCSrc, PCTarget, JalrTarget,
      output PC, PCPlus4, PCValid, MisalignTrap, EPC, BadAddr
   );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC selection with misaligned-target trapping and a BOOT/RUN/TRAP sequencer.
// PC only advances in RUN; BOOT and TRAP each last one cycle and ignore their inputs.
module pc_next_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
   input  logic          clk,
   input  logic          reset,
   pc_next_unit_if.slave bus
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      TRAP
   } state_t;

   localparam logic [XLEN-1:0] BIT0_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] badAddr_q, badAddr_d;
   logic            trap_q, trap_d;

   logic [XLEN-1:0] pcPlus4;
   logic [XLEN-1:0] candidate;
   logic            misaligned;

   assign pcPlus4 = pc_q + XLEN'(4);

   // JALR clears bit 0 before the alignment check; EPC is always word-aligned so it never traps.
   always_comb begin
      candidate = pcPlus4;
      case (bus.PCSrc)
         2'd0:    candidate = pcPlus4;
         2'd1:    candidate = bus.PCTarget;
         2'd2:    candidate = bus.JalrTarget & BIT0_MASK;
         default: candidate = epc_q;
      endcase
   end

   assign misaligned = (bus.PCSrc != 2'd3) && (candidate[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VECTOR;
         epc_q     <= '0;
         badAddr_q <= '0;
         trap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         badAddr_q <= badAddr_d;
         trap_q    <= trap_d;
      end
   end

   // Stall outranks the alignment check, which outranks the redirect itself.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      badAddr_d = badAddr_q;
      trap_d    = 1'b0;
      case (state_q)
         BOOT: begin
            pc_d    = RESET_VECTOR;
            state_d = RUN;
         end
         RUN: begin
            if (!bus.Stall) begin
               if (misaligned) begin
                  pc_d      = TRAP_VECTOR;
                  epc_d     = pc_q;
                  badAddr_d = candidate;
                  trap_d    = 1'b1;
                  state_d   = TRAP;
               end else begin
                  pc_d = candidate;
               end
            end
         end
         TRAP: begin
            pc_d    = TRAP_VECTOR;
            state_d = RUN;
         end
         default: begin
            pc_d    = RESET_VECTOR;
            state_d = BOOT;
         end
      endcase
   end

   assign bus.PC           = pc_q;
   assign bus.PCPlus4      = pcPlus4;
   assign bus.PCValid      = (state_q == RUN);
   assign bus.MisalignTrap = trap_q;
   assign bus.EPC          = epc_q;
   assign bus.BadAddr      = badAddr_q;

endmodule
